// File: rtl/qd1_timer_service.sv
// Avalon-MM master for the QD1 system timer: programs and verifies the timer after reset,
// services its interrupts (tick pulse + tick count) and applies runtime period changes.
module qd1_timer_service #(
    parameter logic [31:0] PERIOD_DEFAULT = 32'd49999,
    parameter int          MAX_ATTEMPTS   = 3
) (
    input  logic        clk,
    input  logic        reset,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic [15:0] tmr_readdata,
    input  logic        tmr_irq,
    input  logic        cfg_valid,
    input  logic [31:0] cfg_period,
    output logic        cfg_ready,
    output logic        tick_pulse,
    output logic [31:0] tick_count,
    output logic        init_done,
    output logic        cfg_error
);

    // state   | meaning
    // INIT    | load default period, attempt = 1, wait for reset release to settle
    // WR_PL   | write period low half (addr 2)
    // WR_PH   | write period high half (addr 3)
    // WR_CTRL | write START|CONT|ITO (addr 1)
    // RD_CTRL | present control read (addr 1)
    // RD_CHK  | compare registered read data, retry or run
    // RUN     | idle, waiting for interrupt or period request
    // CLR     | write status (addr 0) to acknowledge the interrupt
    // FAULT   | verification gave up; bus silent until reset

    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    localparam logic [15:0] CTRL_RUN = 16'h0007;

    typedef enum logic [3:0] {
        INIT,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RD_CTRL,
        RD_CHK,
        RUN,
        CLR,
        FAULT
    } state_t;

    state_t          state;
    logic            reset_q;
    logic [31:0]     period_q;
    logic [AW-1:0]   attempts;
    logic [31:0]     tick_cnt_q;

    // Only the low nibble of the control read-back carries the bits we program.
    logic unused_readdata_hi;
    assign unused_readdata_hi = ^tmr_readdata[15:4];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            reset_q    <= 1'b1;
            period_q   <= PERIOD_DEFAULT;
            attempts   <= AW'(1);
            tick_cnt_q <= 32'd0;
            init_done  <= 1'b0;
            cfg_error  <= 1'b0;
        end else begin
            reset_q <= 1'b0;
            case (state)
                INIT: begin
                    period_q <= PERIOD_DEFAULT;
                    attempts <= AW'(1);
                    // Hold one extra cycle after release so the timer sees an idle bus first.
                    if (!reset_q) begin
                        state <= WR_PL;
                    end
                end
                WR_PL:   state <= WR_PH;
                WR_PH:   state <= WR_CTRL;
                WR_CTRL: state <= RD_CTRL;
                RD_CTRL: state <= RD_CHK;
                RD_CHK: begin
                    if (tmr_readdata[3:0] == CTRL_RUN[3:0]) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end else begin
                        cfg_error <= 1'b1;
                        if (int'(attempts) < MAX_ATTEMPTS) begin
                            attempts <= attempts + AW'(1);
                            state    <= WR_PL;
                        end else begin
                            state <= FAULT;
                        end
                    end
                end
                RUN: begin
                    if (tmr_irq) begin
                        state <= CLR;
                    end else if (cfg_valid) begin
                        period_q  <= cfg_period;
                        init_done <= 1'b0;
                        attempts  <= AW'(1);
                        state     <= WR_PL;
                    end
                end
                CLR: begin
                    tick_cnt_q <= tick_cnt_q + 32'd1;
                    state      <= RUN;
                end
                FAULT: init_done <= 1'b0;
                default: state <= INIT;
            endcase
        end
    end

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        case (state)
            WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd2;
                tmr_writedata  = period_q[15:0];
            end
            WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd3;
                tmr_writedata  = period_q[31:16];
            end
            WR_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = CTRL_RUN;
            end
            RD_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd1;
            end
            CLR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
            end
            default: ;
        endcase
    end

    assign cfg_ready  = (state == RUN) && !tmr_irq;
    assign tick_pulse = (state == CLR);
    assign tick_count = tick_cnt_q;

endmodule

// File: tb/tb_qd1_timer_service.sv
// Bench for qd1_timer_service: a behavioural timer slave, a bus transaction log,
// a table of period requests and directed sequences for ticks, faults and resets.
module tb_qd1_timer_service;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;
    logic        cfg_valid;
    logic [31:0] cfg_period;
    logic        cfg_ready;
    logic        tick_pulse;
    logic [31:0] tick_count;
    logic        init_done;
    logic        cfg_error;

    always #5 clk = ~clk;

    qd1_timer_service dut (
        .clk(clk), .reset(reset),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
        .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
        .cfg_valid(cfg_valid), .cfg_period(cfg_period), .cfg_ready(cfg_ready),
        .tick_pulse(tick_pulse), .tick_count(tick_count),
        .init_done(init_done), .cfg_error(cfg_error)
    );

    // Timer slave model: period+1 clocks per timeout, period write stops and reloads.
    logic [15:0] m_pl, m_ph, m_ctrl, rd_q;
    logic        m_to, m_run, bad_ctrl;
    logic [31:0] m_cnt;

    assign tmr_readdata = rd_q;
    assign tmr_irq      = m_to & m_ctrl[0];

    always @(posedge clk) begin
        if (reset) begin
            m_pl <= 16'h0; m_ph <= 16'h0; m_ctrl <= 16'h0; rd_q <= 16'h0;
            m_to <= 1'b0; m_run <= 1'b0; m_cnt <= 32'd0;
        end else begin
            if (m_run) begin
                if (m_cnt == 32'd0) begin
                    m_to  <= 1'b1;
                    m_cnt <= {m_ph, m_pl};
                    if (!m_ctrl[1]) m_run <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 32'd1;
                end
            end
            if (tmr_chipselect && tmr_write_n) begin
                case (tmr_address)
                    3'd0:    rd_q <= {15'h0, m_to};
                    3'd1:    rd_q <= bad_ctrl ? 16'h0000 : m_ctrl;
                    3'd2:    rd_q <= m_pl;
                    3'd3:    rd_q <= m_ph;
                    default: rd_q <= 16'h0;
                endcase
            end
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    3'd0: m_to <= 1'b0;
                    3'd1: begin
                        m_ctrl <= tmr_writedata;
                        if (tmr_writedata[2]) m_run <= 1'b1;
                    end
                    3'd2: begin
                        m_pl <= tmr_writedata; m_run <= 1'b0; m_cnt <= {m_ph, tmr_writedata};
                    end
                    3'd3: begin
                        m_ph <= tmr_writedata; m_run <= 1'b0; m_cnt <= {tmr_writedata, m_pl};
                    end
                    default: ;
                endcase
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
        int          idx;
    } txn_t;

    txn_t log_q[$];
    int   edges = 0;
    int   rel = 0;

    always @(posedge clk) edges <= edges + 1;

    always @(posedge clk) begin
        txn_t t;
        if (tmr_chipselect) begin
            t.wr   = !tmr_write_n;
            t.addr = tmr_address;
            t.data = tmr_writedata;
            t.idx  = edges - rel;
            log_q.push_back(t);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_txn(input string nm, input int i, input logic wr, input logic [2:0] a,
                           input logic [15:0] d);
        if (i >= log_q.size()) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: transaction %0d missing, log holds %0d expected %0d", nm, i,
                     log_q.size(), i + 1);
        end else begin
            chk(nm, 32'({log_q[i].wr, log_q[i].addr, log_q[i].data}), 32'({wr, a, d}));
        end
    endtask

    task automatic wait_init(input int bound, output int rise_idx);
        bit seen = 1'b0;
        rise_idx = -1;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (init_done) begin
                seen = 1'b1;
                rise_idx = edges - rel - 1;
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL init_timeout: init_done got 0 expected 1 within %0d cycles", bound);
        end
    endtask

    task automatic wait_irq(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (tmr_irq) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL irq_timeout: tmr_irq got 0 expected 1 within %0d cycles", bound);
        end
    endtask

    // Called on a negedge; returns on the negedge right after the accepting posedge.
    task automatic issue_cfg(input logic [31:0] p);
        bit acc = 1'b0;
        cfg_period = p;
        cfg_valid  = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (cfg_ready) acc = 1'b1;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL cfg_accept_timeout: cfg_ready got 0 expected 1");
        end
    endtask

    // Releases reset and checks the programming sequence with the default period.
    task automatic boot_check(input string nm);
        int r;
        log_q.delete();
        rel   = edges;
        reset = 1'b0;
        wait_init(20, r);
        chk({nm, "_init_done_latency"}, 32'(r), 32'd6);
        chk_txn({nm, "_wr_pl"}, 0, 1'b1, 3'd2, 16'hC34F);
        if (log_q.size() > 0) chk({nm, "_wr_pl_latency"}, 32'(log_q[0].idx), 32'd2);
        chk_txn({nm, "_wr_ph"}, 1, 1'b1, 3'd3, 16'h0000);
        chk_txn({nm, "_wr_ctrl"}, 2, 1'b1, 3'd1, 16'h0007);
        chk_txn({nm, "_rd_ctrl"}, 3, 1'b0, 3'd1, 16'h0000);
        chk({nm, "_cfg_error"}, 32'(cfg_error), 32'd0);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_chipselect"}, 32'(tmr_chipselect), 32'd0);
        chk({nm, "_write_n"}, 32'(tmr_write_n), 32'd1);
        chk({nm, "_address"}, 32'(tmr_address), 32'd0);
        chk({nm, "_writedata"}, 32'(tmr_writedata), 32'd0);
        chk({nm, "_tick_pulse"}, 32'(tick_pulse), 32'd0);
        chk({nm, "_tick_count"}, tick_count, 32'd0);
        chk({nm, "_init_done"}, 32'(init_done), 32'd0);
        chk({nm, "_cfg_error"}, 32'(cfg_error), 32'd0);
        chk({nm, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
    endtask

    typedef struct {
        logic [31:0] period;
        logic [15:0] lo;
        logic [15:0] hi;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int  r;
        bit  ok;
        int  last_rise;
        int  n_clr;

        vecs[0] = '{32'hDEAD_BEEF, 16'hBEEF, 16'hDEAD};
        vecs[1] = '{32'h0001_0000, 16'h0000, 16'h0001};
        vecs[2] = '{32'd9,         16'h0009, 16'h0000};

        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_period = 32'd0;
        bad_ctrl   = 1'b0;
        last_rise  = 0;
        repeat (3) @(negedge clk);
        chk_idle("reset");

        boot_check("boot");

        for (int v = 0; v < 3; v++) begin
            issue_cfg(vecs[v].period);
            log_q.delete();
            chk($sformatf("vec%0d_init_done_cleared", v), 32'(init_done), 32'd0);
            wait_init(20, r);
            chk_txn($sformatf("vec%0d_wr_pl", v), 0, 1'b1, 3'd2, vecs[v].lo);
            chk_txn($sformatf("vec%0d_wr_ph", v), 1, 1'b1, 3'd3, vecs[v].hi);
            chk_txn($sformatf("vec%0d_wr_ctrl", v), 2, 1'b1, 3'd1, 16'h0007);
            chk_txn($sformatf("vec%0d_rd_ctrl", v), 3, 1'b0, 3'd1, 16'h0000);
            chk($sformatf("vec%0d_timer_period", v), {m_ph, m_pl}, vecs[v].period);
        end

        // Five ticks at period 9: ten cycles apart, each acknowledged in two cycles.
        log_q.delete();
        chk("ticks_start_count", tick_count, 32'd0);
        for (int t = 0; t < 5; t++) begin
            wait_irq(40, ok);
            if (ok) begin
                if (t > 0) chk($sformatf("tick%0d_interval", t), 32'(edges - last_rise), 32'd10);
                last_rise = edges;
                chk($sformatf("tick%0d_pulse_before", t), 32'(tick_pulse), 32'd0);
                @(negedge clk);
                chk($sformatf("tick%0d_pulse_clr", t), 32'(tick_pulse), 32'd1);
                @(negedge clk);
                chk($sformatf("tick%0d_irq_low", t), 32'(tmr_irq), 32'd0);
                chk($sformatf("tick%0d_pulse_after", t), 32'(tick_pulse), 32'd0);
            end
        end
        chk("ticks_count", tick_count, 32'd5);
        n_clr = 0;
        foreach (log_q[i]) if (log_q[i].wr && log_q[i].addr == 3'd0) n_clr++;
        chk("ticks_clr_writes", 32'(n_clr), 32'd5);

        // Wrap of the tick counter.
        force dut.tick_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.tick_cnt_q;
        wait_irq(40, ok);
        repeat (2) @(negedge clk);
        chk("wrap_tick_count", tick_count, 32'd0);

        // Period request raised while an interrupt is pending.
        wait_irq(40, ok);
        log_q.delete();
        cfg_period = 32'h0001_86A0;
        cfg_valid  = 1'b1;
        chk("coinc_ready_irq", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        chk("coinc_pulse_clr", 32'(tick_pulse), 32'd1);
        chk("coinc_ready_clr", 32'(cfg_ready), 32'd0);
        issue_cfg(32'h0001_86A0);
        wait_init(20, r);
        chk_txn("coinc_clr_first", 0, 1'b1, 3'd0, 16'h0000);
        chk_txn("coinc_wr_pl", 1, 1'b1, 3'd2, 16'h86A0);
        chk_txn("coinc_wr_ph", 2, 1'b1, 3'd3, 16'h0001);
        chk_txn("coinc_wr_ctrl", 3, 1'b1, 3'd1, 16'h0007);
        chk("coinc_tick_count", tick_count, 32'd1);
        chk("coinc_timer_period", {m_ph, m_pl}, 32'h0001_86A0);

        // Reset asserted while the high-period write is on the bus.
        issue_cfg(32'd9);
        @(negedge clk);
        chk("midrst_in_wr_ph", 32'({tmr_chipselect, tmr_write_n, tmr_address}), 32'({1'b1, 1'b0, 3'd3}));
        reset = 1'b1;
        @(negedge clk);
        chk_idle("midrst");
        boot_check("reboot");

        // Control read-back always wrong: three attempts, then silence.
        bad_ctrl = 1'b1;
        issue_cfg(32'd9);
        log_q.delete();
        repeat (60) @(negedge clk);
        chk("fault_txn_count", 32'(log_q.size()), 32'd12);
        for (int a = 0; a < 3; a++) begin
            chk_txn($sformatf("fault%0d_wr_pl", a), 4 * a, 1'b1, 3'd2, 16'h0009);
            chk_txn($sformatf("fault%0d_wr_ph", a), 4 * a + 1, 1'b1, 3'd3, 16'h0000);
            chk_txn($sformatf("fault%0d_wr_ctrl", a), 4 * a + 2, 1'b1, 3'd1, 16'h0007);
            chk_txn($sformatf("fault%0d_rd_ctrl", a), 4 * a + 3, 1'b0, 3'd1, 16'h0000);
        end
        chk("fault_cfg_error", 32'(cfg_error), 32'd1);
        chk("fault_init_done", 32'(init_done), 32'd0);
        chk("fault_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("fault_chipselect", 32'(tmr_chipselect), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
